// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
// Shared constants and types for the IF/ID pipeline slice: the NOP encoding,
// the default reset PC, the EX control-bit index for "memory read", the
// instruction field bit positions, and the IF/ID register record.
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned M_MEM_READ_BIT   = 1;      // index of mem-read in EX_m
    localparam logic [15:0] STALL_CNT_MAX    = 16'hFFFF;

    // Instruction field positions (rs, rt, rd).
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_reg_t;

    // Sequential fetch address; the 32-bit result wraps naturally.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector. Flags a hazard when the instruction in EX
// is a load whose destination (non-zero rt) matches either source register
// of the instruction sitting in ID.
//   EX_mem_read : EX-stage instruction is a load
//   EX_rt       : EX-stage load destination register
//   ID_rs/ID_rt : source register fields of the ID-stage instruction
//   hazard      : stall request for the IF/ID stage
// ---------------------------------------------------------------------------
module hazard_detect (
    input  logic       EX_mem_read,
    input  logic [4:0] EX_rt,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    output logic       hazard
);

    // Register 0 is never a real destination, so a NOP in ID (rs=rt=0)
    // can never match.
    assign hazard = EX_mem_read && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (EX_rt == ID_rt));

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// Program counter, IF/ID pipeline register and load-use stall counter.
// Each cycle the stage either advances (PC+4), holds for one load-use stall,
// or redirects to a MEM-resolved branch target while flushing ID to a NOP.
// A taken branch outranks a simultaneous stall.
//   clk, startin           : clock, asynchronous active-high reset
//   IF_instr               : instruction word fetched at IF_pc (same cycle)
//   EX_mem_read, EX_rt     : load in EX and its destination register
//   MEM_pc_src             : branch taken (resolved in MEM)
//   MEM_branch_target      : branch target address
//   IF_pc                  : current fetch address
//   ID_instr, ID_pc_plus4  : IF/ID register contents
//   ID_instr_25_21/20_16/15_11 : field slices of ID_instr
//   ID_bubble              : zero the ID control bits (stall or flush)
//   stall_cnt              : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        startin,
    input  logic [31:0] IF_instr,
    input  logic        EX_mem_read,
    input  logic [4:0]  EX_rt,
    input  logic        MEM_pc_src,
    input  logic [31:0] MEM_branch_target,
    output logic [31:0] IF_pc,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pc_plus4,
    output logic [4:0]  ID_instr_25_21,
    output logic [4:0]  ID_instr_20_16,
    output logic [4:0]  ID_instr_15_11,
    output logic        ID_bubble,
    output logic [15:0] stall_cnt
);

    logic [31:0] pc_q,    pc_d;
    if_id_reg_t  if_id_q, if_id_d;
    logic [15:0] stall_q, stall_d;
    logic        hazard;

    hazard_detect u_hazard_detect (
        .EX_mem_read (EX_mem_read),
        .EX_rt       (EX_rt),
        .ID_rs       (if_id_q.instr[RS_MSB:RS_LSB]),
        .ID_rt       (if_id_q.instr[RT_MSB:RT_LSB]),
        .hazard      (hazard)
    );

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        stall_d = stall_q;
        if (MEM_pc_src) begin
            // Flush: the fetched word is on the wrong path.
            pc_d             = MEM_branch_target;
            if_id_d.instr    = NOP_INSTR;
            if_id_d.pc_plus4 = 32'h0;
        end else if (hazard) begin
            // Hold PC and IF/ID for one cycle; the load leaves EX meanwhile.
            if (stall_q != STALL_CNT_MAX) begin
                stall_d = stall_q + 16'd1;
            end
        end else begin
            pc_d             = pc_plus4(pc_q);
            if_id_d.instr    = IF_instr;
            if_id_d.pc_plus4 = pc_plus4(pc_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            pc_q             <= RESET_PC;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc_plus4 <= 32'h0;
            stall_q          <= 16'h0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            stall_q <= stall_d;
        end
    end

    assign IF_pc          = pc_q;
    assign ID_instr       = if_id_q.instr;
    assign ID_pc_plus4    = if_id_q.pc_plus4;
    assign ID_instr_25_21 = if_id_q.instr[RS_MSB:RS_LSB];
    assign ID_instr_20_16 = if_id_q.instr[RT_MSB:RT_LSB];
    assign ID_instr_15_11 = if_id_q.instr[RD_MSB:RD_LSB];
    assign ID_bubble      = hazard | MEM_pc_src;
    assign stall_cnt      = stall_q;

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port startin, input, 1, reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port IF_instr, input, 32, instruction word returned by instruction memory for IF_pc, same cycle.
REQ-005 SHALL have port EX_mem_read, input, 1, EX-stage instruction is a load (EX_m bit 1).
REQ-006 SHALL have port EX_rt, input, 5, EX-stage destination rt (EX_instr_20_16).
REQ-007 SHALL have port MEM_pc_src, input, 1, branch taken, resolved in MEM.
REQ-008 SHALL have port MEM_branch_target, input, 32, branch target address.
REQ-009 SHALL have port IF_pc, output, 32, current fetch address.
REQ-010 SHALL have port ID_instr, output, 32, IF/ID instruction register.
REQ-011 SHALL have port ID_pc_plus4, output, 32, IF/ID PC+4 register.
REQ-012 SHALL have ports ID_instr_25_21, ID_instr_20_16, ID_instr_15_11, output, 5 each, field slices of ID_instr.
REQ-013 SHALL have port ID_bubble, output, 1, forces ID_wb/ID_m/ID_ex to zero before the ID/EX register.
REQ-014 SHALL have port stall_cnt, output, 16, saturating count of load-use stall cycles.

Function
REQ-015 hazard SHALL be combinational: EX_mem_read && EX_rt != 0 && (EX_rt == ID_instr[25:21] || EX_rt == ID_instr[20:16]).
REQ-016 Normal cycle (no hazard, no MEM_pc_src): IF_pc <= IF_pc+4; ID_instr <= IF_instr; ID_pc_plus4 <= IF_pc+4.
REQ-017 Latency SHALL be 1 cycle: word fetched at IF_pc in cycle n appears on ID_instr in cycle n+1.
REQ-018 Hazard, no MEM_pc_src: IF_pc, ID_instr, ID_pc_plus4 SHALL hold; ID_bubble=1; exactly one stall cycle per load-use pair (hazard clears once load leaves EX).
REQ-019 MEM_pc_src=1: IF_pc <= MEM_branch_target; ID_instr <= 32'h0 (NOP); ID_pc_plus4 <= 0; ID_bubble=1 same cycle.
REQ-020 MEM_pc_src SHALL take priority over hazard when both asserted in the same cycle; no stall counted.
REQ-021 ID_bubble SHALL equal hazard | MEM_pc_src, combinational.
REQ-022 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0); no carry-out.
REQ-023 stall_cnt SHALL increment by 1 on each cycle where REQ-018 applies; hold at 16'hFFFF.
REQ-024 NOP (32'h0) in ID SHALL never cause a hazard (rs=rt=0, excluded by EX_rt != 0).
REQ-025 Field outputs (REQ-012) SHALL be pure wiring of ID_instr, no extra register.

Reset
REQ-026 startin=1 SHALL immediately, regardless of clk, set IF_pc=RESET_PC, ID_instr=0, ID_pc_plus4=0, stall_cnt=0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL discard the pending operation; first edge after release fetches RESET_PC.
REQ-028 ID_bubble during reset SHALL follow REQ-021 from its inputs (ID_instr=0 makes hazard 0).

Structure
REQ-029 Shared package SHALL hold NOP_INSTR=32'h0, default RESET_PC, M_MEM_READ_BIT=1, and instruction field index constants.
REQ-030 Load-use comparison SHALL be one combinational sub-module, hazard_detect (inputs: EX_mem_read, EX_rt, ID rs, ID rt; output: hazard).
REQ-031 PC register, IF/ID register and stall counter SHALL reside in if_id_stage.

Verification
REQ-032 Reset: assert startin between edges -> IF_pc=0, ID_instr=0, stall_cnt=0 without a clock edge; release -> IF_pc 0,4,8 on next three edges.
REQ-033 Load-use: ID_instr rs=5, EX_mem_read=1, EX_rt=5 for one cycle -> ID_bubble=1, IF_pc and ID_instr unchanged one edge, stall_cnt=1, then advance.
REQ-034 No false hazard: EX_rt=0 with EX_mem_read=1 and ID rs=0 -> ID_bubble=0, pipeline advances.
REQ-035 Branch: MEM_pc_src=1, target 32'h0000_0100 -> next edge IF_pc=0x100, ID_instr=0; simultaneous hazard ignored, stall_cnt unchanged.
REQ-036 Wrap: RESET_PC=32'hFFFF_FFFC -> after one edge IF_pc=0, ID_pc_plus4=0.
REQ-037 Saturation: force 65536 hazard cycles -> stall_cnt stays 16'hFFFF.
